vga_fb_reader: RTL and testbench

- Video-side read engine for the 4096x8 frame-buffer RAM.
- Generates 640x480@60 VGA timing, scans a 64x48 frame buffer in which each byte is one RGB332 cell, and scales each cell to 10x10 screen pixels.
- Issues read addresses to the RAM's read port and turns the returned bytes into RGB and sync outputs.
- Sits between the frame-buffer RAM and the board DAC/pins. The write side of the RAM is owned elsewhere.

---
 rtl/vga_fb_reader.sv | 139 +++++++++++++
 tb/tb_vga_fb_reader.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/vga_fb_reader.sv
// Video read engine: 640x480@60 timing, 64x48 RGB332 cell scan scaled SCALE x SCALE, two-tick pixel pipeline.
// Pixel-tick latency is 2 for RGB, syncs and o_active alike; there is no backpressure, and everything holds while i_en is low.
module vga_fb_reader #(
   parameter int unsigned H_ACTIVE  = 640,
   parameter int unsigned H_FP      = 16,
   parameter int unsigned H_SYNC    = 96,
   parameter int unsigned H_BP      = 48,
   parameter int unsigned V_ACTIVE  = 480,
   parameter int unsigned V_FP      = 10,
   parameter int unsigned V_SYNC    = 2,
   parameter int unsigned V_BP      = 33,
   parameter int unsigned SCALE     = 10,
   parameter logic        SYNC_POL  = 1'b0,
   parameter logic [11:0] ADDR_BASE = 12'h000
) (
   input  logic        i_clk,
   input  logic        i_rst,
   input  logic        i_en,
   input  logic [7:0]  i_dout,
   output logic [11:0] o_addr,
   output logic        o_hsync,
   output logic        o_vsync,
   output logic [2:0]  o_r,
   output logic [2:0]  o_g,
   output logic [1:0]  o_b,
   output logic        o_active,
   output logic        o_frame_start
);

   localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

   localparam logic [9:0] LP_H_ACT    = 10'(H_ACTIVE);
   localparam logic [9:0] LP_H_LAST   = 10'(H_TOTAL - 1);
   localparam logic [9:0] LP_HS_BEG   = 10'(H_ACTIVE + H_FP);
   localparam logic [9:0] LP_HS_END   = 10'(H_ACTIVE + H_FP + H_SYNC);
   localparam logic [9:0] LP_V_ACT    = 10'(V_ACTIVE);
   localparam logic [9:0] LP_V_LAST   = 10'(V_TOTAL - 1);
   localparam logic [9:0] LP_VS_BEG   = 10'(V_ACTIVE + V_FP);
   localparam logic [9:0] LP_VS_END   = 10'(V_ACTIVE + V_FP + V_SYNC);
   localparam logic [7:0] LP_SUB_LAST = 8'(SCALE - 1);

   logic [9:0]  r_h, r_v;
   logic [7:0]  r_hsub, r_vsub;
   logic [6:0]  r_col;
   logic [5:0]  r_row;
   logic        r_active_d1, r_hs_d1, r_vs_d1, r_fs_d1;

   logic        w_h_vis, w_v_vis, w_hs, w_vs, w_h_last, w_v_last;
   logic [11:0] w_addr;

   assign w_h_vis  = (r_h < LP_H_ACT);
   assign w_v_vis  = (r_v < LP_V_ACT);
   assign w_hs     = (r_h >= LP_HS_BEG) && (r_h < LP_HS_END);
   assign w_vs     = (r_v >= LP_VS_BEG) && (r_v < LP_VS_END);
   assign w_h_last = (r_h == LP_H_LAST);
   assign w_v_last = (r_v == LP_V_LAST);
   // Row stride is 64 cells; sum deliberately wraps mod 4096.
   assign w_addr   = ADDR_BASE + {r_row, 6'b0} + {5'b0, r_col};

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_h    <= '0;
         r_v    <= '0;
         r_hsub <= '0;
         r_vsub <= '0;
         r_col  <= '0;
         r_row  <= '0;
      end else if (i_en) begin
         if (w_h_last) begin
            r_h    <= '0;
            r_hsub <= '0;
            r_col  <= '0;
            if (w_v_last) begin
               r_v    <= '0;
               r_vsub <= '0;
               r_row  <= '0;
            end else begin
               r_v <= r_v + 10'd1;
               if (w_v_vis) begin
                  if (r_vsub == LP_SUB_LAST) begin
                     r_vsub <= '0;
                     r_row  <= r_row + 6'd1;
                  end else begin
                     r_vsub <= r_vsub + 8'd1;
                  end
               end
            end
         end else begin
            r_h <= r_h + 10'd1;
            if (w_h_vis) begin
               if (r_hsub == LP_SUB_LAST) begin
                  r_hsub <= '0;
                  r_col  <= r_col + 7'd1;
               end else begin
                  r_hsub <= r_hsub + 8'd1;
               end
            end
         end
      end
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         o_addr        <= ADDR_BASE;
         r_active_d1   <= 1'b0;
         r_hs_d1       <= 1'b0;
         r_vs_d1       <= 1'b0;
         r_fs_d1       <= 1'b0;
         o_r           <= '0;
         o_g           <= '0;
         o_b           <= '0;
         o_active      <= 1'b0;
         o_hsync       <= ~SYNC_POL;
         o_vsync       <= ~SYNC_POL;
         o_frame_start <= 1'b0;
      end else begin
         o_frame_start <= 1'b0;
         if (i_en) begin
            if (w_h_vis && w_v_vis) begin
               o_addr <= w_addr;
            end
            r_active_d1   <= w_h_vis && w_v_vis;
            r_hs_d1       <= w_hs;
            r_vs_d1       <= w_vs;
            r_fs_d1       <= (r_h == 10'd0) && (r_v == 10'd0);
            // RAM data for the previous tick's address is valid by now.
            o_r           <= r_active_d1 ? i_dout[7:5] : 3'd0;
            o_g           <= r_active_d1 ? i_dout[4:2] : 3'd0;
            o_b           <= r_active_d1 ? i_dout[1:0] : 2'd0;
            o_active      <= r_active_d1;
            o_hsync       <= r_hs_d1 ? SYNC_POL : ~SYNC_POL;
            o_vsync       <= r_vs_d1 ? SYNC_POL : ~SYNC_POL;
            o_frame_start <= r_fs_d1;
         end
      end
   end

endmodule

// File: tb/tb_vga_fb_reader.sv
// Directed bench: full-size instance for line timing, mapping, gating and reset;
// a shrunken SCALE=1 instance at base 12'hC00 for whole-frame timing and address wrap.
module tb_vga_fb_reader;

   logic        clk = 1'b0;
   logic        rst;
   logic        en_a, en_b;
   logic        ff_a, ff_b;
   logic [7:0]  dout_a, dout_b;
   logic [11:0] addr_a, addr_b;
   logic        hs_a, vs_a, act_a, fs_a;
   logic        hs_b, vs_b, act_b, fs_b;
   logic [2:0]  r_a, g_a, r_b, g_b;
   logic [1:0]  b_a, b_b;
   logic [7:0]  rgb_a, rgb_b;

   int n_chk  = 0;
   int n_pass = 0;

   always #5 clk = ~clk;

   assign rgb_a = {r_a, g_a, b_a};
   assign rgb_b = {r_b, g_b, b_b};

   // RAM models: mem[a] = a[7:0], or constant 0xFF when the ff flag is set.
   always @(posedge clk) dout_a <= ff_a ? 8'hFF : addr_a[7:0];
   always @(posedge clk) dout_b <= ff_b ? 8'hFF : addr_b[7:0];

   vga_fb_reader dut_a (
      .i_clk(clk), .i_rst(rst), .i_en(en_a), .i_dout(dout_a), .o_addr(addr_a),
      .o_hsync(hs_a), .o_vsync(vs_a), .o_r(r_a), .o_g(g_a), .o_b(b_a),
      .o_active(act_a), .o_frame_start(fs_a)
   );

   vga_fb_reader #(
      .H_ACTIVE(64), .H_FP(2), .H_SYNC(4), .H_BP(2),
      .V_ACTIVE(48), .V_FP(2), .V_SYNC(2), .V_BP(2),
      .SCALE(1), .SYNC_POL(1'b0), .ADDR_BASE(12'hC00)
   ) dut_b (
      .i_clk(clk), .i_rst(rst), .i_en(en_b), .i_dout(dout_b), .o_addr(addr_b),
      .o_hsync(hs_b), .o_vsync(vs_b), .o_r(r_b), .o_g(g_b), .o_b(b_b),
      .o_active(act_b), .o_frame_start(fs_b)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      else n_pass++;
   endtask

   // One pixel tick: enable high for one clock, then one idle clock; returns at the sample point.
   task automatic tick(input bit which);
      @(negedge clk);
      if (which) en_b = 1'b1;
      else       en_a = 1'b1;
      @(negedge clk);
      en_a = 1'b0;
      en_b = 1'b0;
   endtask

   initial begin
      int hs_low, act_cnt, fall1, fall2, bad, vs_low_any;
      int vs_low, vfall1, vfall2, k, hh, vv;
      bit prev_hs, prev_vs, exp_act;

      rst = 1'b1; en_a = 1'b0; en_b = 1'b0; ff_a = 1'b0; ff_b = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_addr_a", addr_a, 12'h000);
      chk("rst_addr_b", addr_b, 12'hC00);
      chk("rst_sync_a", {hs_a, vs_a}, 2'b11);
      chk("rst_rgb_a", rgb_a, 8'h00);
      chk("rst_act_fs_a", {act_a, fs_a}, 2'b00);
      rst = 1'b0;

      // Full-size instance: lines 0..10, blanking with 0xFF RAM on lines 1..8.
      hs_low = 0; act_cnt = 0; fall1 = -1; fall2 = -1; bad = 0; vs_low_any = 0; prev_hs = 1'b1;
      for (int n = 0; n <= 8300; n++) begin
         tick(1'b0);
         if (n >= 1 && n <= 800) begin
            if (!hs_a) hs_low++;
            if (act_a) act_cnt++;
         end
         if (prev_hs && !hs_a) begin
            if (fall1 < 0) fall1 = n;
            else if (fall2 < 0) fall2 = n;
         end
         prev_hs = hs_a;
         if (!vs_a) vs_low_any++;
         if (n >= 801 && n <= 7200) begin
            hh = (n - 1) % 800;
            if (hh >= 640 && (act_a || rgb_a != 8'h00)) bad++;
            if (hh < 640 && !act_a) bad++;
         end
         if (n == 799)  ff_a = 1'b1;
         if (n == 7199) ff_a = 1'b0;
         case (n)
            0: begin
               chk("t0_addr", addr_a, 12'd0);
               chk("t0_fs_act", {fs_a, act_a}, 2'b00);
            end
            1: begin
               chk("t1_fs_act", {fs_a, act_a}, 2'b11);
               chk("t1_rgb", rgb_a, 8'h00);
            end
            2:    chk("t2_fs", fs_a, 1'b0);
            10: begin
               chk("h10_addr", addr_a, 12'd1);
               chk("h9_rgb", rgb_a, 8'h00);
            end
            11:   chk("h10_rgb", rgb_a, 8'h01);
            640:  chk("h640_addr_hold", addr_a, 12'd63);
            800: begin
               chk("line_hs_low", hs_low, 96);
               chk("line_active", act_cnt, 640);
            end
            806:  chk("ff_active_rgb", {act_a, rgb_a}, {1'b1, 8'hFF});
            7200: chk("blank_bad", bad, 0);
            8000: chk("v10_addr", addr_a, 12'd64);
            8001: begin
               chk("v10_rgb", rgb_a, 8'h40);
               chk("v10_r", r_a, 3'd2);
            end
            8123: begin
               chk("gate_addr_pre", addr_a, 12'd76);
               repeat (100) @(negedge clk);
               chk("gate_addr", addr_a, 12'd76);
               chk("gate_rgb", rgb_a, 8'h4C);
               chk("gate_sync", {hs_a, vs_a}, 2'b11);
            end
            8129: chk("resume_addr76", addr_a, 12'd76);
            8130: chk("resume_addr77", addr_a, 12'd77);
            8300: chk("pre_rst_addr", addr_a, 12'd94);
            default: ;
         endcase
      end
      chk("hs_fall1", fall1, 657);
      chk("hs_period", fall2 - fall1, 800);
      chk("vs_idle", vs_low_any, 0);

      // Asynchronous reset mid-frame: outputs must clear before any clock edge.
      @(negedge clk);
      #1 rst = 1'b1;
      #1;
      chk("arst_addr", addr_a, 12'd0);
      chk("arst_rgb_act", {rgb_a, act_a, fs_a}, 10'd0);
      repeat (3) @(negedge clk);
      rst = 1'b0;
      tick(1'b0);
      chk("rel_t0", {addr_a, fs_a}, {12'd0, 1'b0});
      tick(1'b0);
      chk("rel_t1_fs", {fs_a, act_a}, 2'b11);
      @(negedge clk);
      chk("fs_one_clock", fs_a, 1'b0);

      // Shrunken instance: two whole frames, 0xFF RAM during the second.
      hs_low = 0; vs_low = 0; act_cnt = 0; fall1 = -1; fall2 = -1; vfall1 = -1; vfall2 = -1;
      bad = 0; prev_hs = 1'b1; prev_vs = 1'b1;
      for (int n = 0; n <= 7777; n++) begin
         tick(1'b1);
         if (n >= 1 && n <= 3888) begin
            if (!hs_b) hs_low++;
            if (!vs_b) vs_low++;
            if (act_b) act_cnt++;
         end
         if (prev_hs && !hs_b) begin
            if (fall1 < 0) fall1 = n;
            else if (fall2 < 0) fall2 = n;
         end
         if (prev_vs && !vs_b) begin
            if (vfall1 < 0) vfall1 = n;
            else if (vfall2 < 0) vfall2 = n;
         end
         prev_hs = hs_b;
         prev_vs = vs_b;
         if (n >= 1) begin
            k = n - 1;
            hh = k % 72;
            vv = (k / 72) % 54;
            exp_act = (hh < 64) && (vv < 48);
            if (act_b !== exp_act) bad++;
            if (!act_b && rgb_b != 8'h00) bad++;
         end
         if (n == 3887) ff_b = 1'b1;
         case (n)
            0:    chk("b_addr_base", addr_b, 12'hC00);
            1:    chk("b_fs_rgb", {fs_b, rgb_b}, {1'b1, 8'h00});
            3447: chk("b_addr_wrap", addr_b, 12'h7FF);
            3448: chk("b_last_rgb", {act_b, rgb_b, addr_b}, {1'b1, 8'hFF, 12'h7FF});
            3889: chk("b_fs_frame2", fs_b, 1'b1);
            3894: chk("b_ff_rgb", rgb_b, 8'hFF);
            default: ;
         endcase
      end
      chk("b_hs_low", hs_low, 216);
      chk("b_hs_fall1", fall1, 67);
      chk("b_hs_period", fall2 - fall1, 72);
      chk("b_vs_low", vs_low, 144);
      chk("b_vs_fall1", vfall1, 3601);
      chk("b_vs_period", vfall2 - vfall1, 3888);
      chk("b_active", act_cnt, 3072);
      chk("b_blank_bad", bad, 0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
